note_tone_gen: RTL and testbench

- Parametrised successor to the single-voice note-to-square-wave converter.
- Converts a 5-bit note code into a speaker square wave, with these additions:
  - clock frequency derived from a parameter
  - octave shift
  - glitch-free note changes on the half-period boundary
  - 2-bit volume via PWM gating
  - load strobe and status outputs
- Sits between the score sequencer and the SPK pin.

---
 rtl/note_tone_gen.sv | 165 ++++++++++++++++
 tb/tb_note_tone_gen.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_tone_gen.sv
// rtl/note_tone_gen.sv - note code to volume-gated square wave with glitch-free note changes
module note_tone_gen #(
  parameter int unsigned CLK_HZ    = 1_000_000,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned OCT_SHIFT = 0,
  parameter int unsigned PWM_W     = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [4:0] note_i,
  input  logic       note_load_i,
  input  logic       play_en_i,
  input  logic [1:0] vol_i,
  output logic       spk_o,
  output logic       busy_o,
  output logic [4:0] cur_note_o
);

  typedef enum logic {IDLE, RUN} state_t;

  // Pitch of each note code in Hz; 0 marks rest and the invalid codes 15..24.
  function automatic int unsigned note_freq(input int unsigned code);
    case (code)
      1:  return 523;   2:  return 587;   3:  return 659;   4:  return 698;
      5:  return 784;   6:  return 880;   7:  return 988;
      8:  return 1047;  9:  return 1175;  10: return 1319;  11: return 1397;
      12: return 1568;  13: return 1760;  14: return 1976;
      25: return 262;   26: return 294;   27: return 330;   28: return 349;
      29: return 392;   30: return 440;   31: return 494;
      default: return 0;
    endcase
  endfunction

  localparam logic [PWM_W-1:0] PWM_QTR  = PWM_W'(1) << (PWM_W - 2);
  localparam logic [PWM_W-1:0] PWM_HALF = PWM_W'(1) << (PWM_W - 1);

  // Half-period ROM: every entry is an elaboration-time constant, rest entries are 0.
  logic [CNT_W-1:0] h_rom [32];
  for (genvar gi = 0; gi < 32; gi++) begin : g_rom
    localparam int unsigned F = note_freq(gi);
    localparam logic [CNT_W-1:0] HV = (F == 0) ? '0 :
      CNT_W'(((longint'(CLK_HZ) + longint'(F)) / (2 * longint'(F))) >> OCT_SHIFT);
    assign h_rom[gi] = HV;
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_h_q, cur_h_d;
  logic [4:0]       cur_note_q, cur_note_d;
  logic             tone_q, tone_d;
  logic [PWM_W-1:0] pwm_q, pwm_d;
  logic             pend_valid_q, pend_valid_d;
  logic [4:0]       pend_note_q, pend_note_d;
  logic [CNT_W-1:0] pend_h_q, pend_h_d;
  logic             spk_q, spk_d;
  logic             apply;
  logic             gate;
  logic             load_is_tone;

  assign load_is_tone = (h_rom[note_i] != '0);

  // Tone FSM, pending-note mailbox, PWM gate and registered speaker drive.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_h_d      = cur_h_q;
    cur_note_d   = cur_note_q;
    tone_d       = tone_q;
    pend_valid_d = pend_valid_q;
    pend_note_d  = pend_note_q;
    pend_h_d     = pend_h_q;
    apply        = 1'b0;
    gate         = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        tone_d = 1'b0;
        if (pend_valid_q) begin
          apply = 1'b1;
          if (pend_note_q != 5'd0) begin
            cur_h_d    = pend_h_q;
            cur_note_d = pend_note_q;
            state_d    = RUN;
          end else begin
            cur_note_d = 5'd0;
          end
        end
      end
      RUN: begin
        if (cnt_q == cur_h_q - CNT_W'(1)) begin
          cnt_d  = '0;
          tone_d = ~tone_q;
          // Half-period boundary: the only point where a new note may take over.
          if (pend_valid_q) begin
            apply = 1'b1;
            if (pend_note_q == 5'd0) begin
              tone_d     = 1'b0;
              cur_h_d    = '0;
              cur_note_d = 5'd0;
              state_d    = IDLE;
            end else begin
              cur_h_d    = pend_h_q;
              cur_note_d = pend_note_q;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A load in the same cycle as an apply refills the mailbox for the next boundary.
    if (note_load_i) begin
      pend_valid_d = 1'b1;
      pend_note_d  = load_is_tone ? note_i : 5'd0;
      pend_h_d     = h_rom[note_i];
    end else if (apply) begin
      pend_valid_d = 1'b0;
    end

    case (vol_i)
      2'd0: gate = 1'b0;
      2'd1: gate = (pwm_q < PWM_QTR);
      2'd2: gate = (pwm_q < PWM_HALF);
      default: gate = 1'b1;
    endcase

    pwm_d = pwm_q + PWM_W'(1);
    spk_d = tone_q & gate & play_en_i;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cur_h_q      <= '0;
      cur_note_q   <= 5'd0;
      tone_q       <= 1'b0;
      pwm_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_note_q  <= 5'd0;
      pend_h_q     <= '0;
      spk_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_h_q      <= cur_h_d;
      cur_note_q   <= cur_note_d;
      tone_q       <= tone_d;
      pwm_q        <= pwm_d;
      pend_valid_q <= pend_valid_d;
      pend_note_q  <= pend_note_d;
      pend_h_q     <= pend_h_d;
      spk_q        <= spk_d;
    end
  end

  assign spk_o      = spk_q;
  assign busy_o     = (state_q == RUN);
  assign cur_note_o = cur_note_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// tb/tb_note_tone_gen.sv - self-checking bench for note_tone_gen against a timestamp model
module tb_note_tone_gen;

  localparam int CLK_HZ = 1_000_000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] note = 5'd0;
  logic       note_load = 1'b0;
  logic       play_en = 1'b0;
  logic [1:0] vol = 2'd0;

  logic       spk_w  [2];
  logic       busy_w [2];
  logic [4:0] cur_w  [2];

  int errors = 0;
  int checks = 0;

  note_tone_gen #(.CLK_HZ(CLK_HZ), .CNT_W(16), .OCT_SHIFT(0), .PWM_W(4)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .note_i(note), .note_load_i(note_load),
    .play_en_i(play_en), .vol_i(vol),
    .spk_o(spk_w[0]), .busy_o(busy_w[0]), .cur_note_o(cur_w[0])
  );

  note_tone_gen #(.CLK_HZ(CLK_HZ), .CNT_W(16), .OCT_SHIFT(1), .PWM_W(4)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .note_i(note), .note_load_i(note_load),
    .play_en_i(play_en), .vol_i(vol),
    .spk_o(spk_w[1]), .busy_o(busy_w[1]), .cur_note_o(cur_w[1])
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int frq(input int c);
    case (c)
      1: return 523;   2: return 587;   3: return 659;   4: return 698;
      5: return 784;   6: return 880;   7: return 988;
      8: return 1047;  9: return 1175;  10: return 1319; 11: return 1397;
      12: return 1568; 13: return 1760; 14: return 1976;
      25: return 262;  26: return 294;  27: return 330;  28: return 349;
      29: return 392;  30: return 440;  31: return 494;
      default: return 0;
    endcase
  endfunction

  function automatic int h_of(input int c, input int sh);
    real f;
    f = real'(frq(c));
    if (f == 0.0) return 0;
    return int'($floor(real'(CLK_HZ) / (2.0 * f) + 0.5)) >> sh;
  endfunction

  // Model: tone level flips at absolute edge numbers; a note change is an event on that timeline.
  bit     m_run [2], m_level [2], m_spk [2], p_valid [2];
  int     m_note [2], m_h [2], p_note [2];
  longint m_nt [2];
  longint e;

  task automatic model_tick();
    int  pw;
    bit  g, spk_n;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_run[i] = 0; m_level[i] = 0; m_spk[i] = 0; p_valid[i] = 0;
        m_note[i] = 0; m_h[i] = 0; p_note[i] = 0; m_nt[i] = 0;
      end
      e = 0;
    end else begin
      pw = int'(e % 16);
      case (vol)
        2'd0: g = 0;
        2'd1: g = (pw < 4);
        2'd2: g = (pw < 8);
        default: g = 1;
      endcase
      for (int i = 0; i < 2; i++) begin
        spk_n = m_level[i] & g & play_en;
        if (!m_run[i]) begin
          if (p_valid[i]) begin
            if (p_note[i] != 0) begin
              m_run[i] = 1; m_h[i] = h_of(p_note[i], i); m_note[i] = p_note[i];
              m_level[i] = 0; m_nt[i] = e + m_h[i];
            end else begin
              m_note[i] = 0;
            end
            p_valid[i] = 0;
          end
        end else if (e == m_nt[i]) begin
          m_level[i] = ~m_level[i];
          if (p_valid[i]) begin
            if (p_note[i] == 0) begin
              m_level[i] = 0; m_run[i] = 0; m_note[i] = 0;
            end else begin
              m_h[i] = h_of(p_note[i], i); m_note[i] = p_note[i];
            end
            p_valid[i] = 0;
          end
          m_nt[i] = e + m_h[i];
        end
        if (note_load) begin
          p_valid[i] = 1;
          p_note[i]  = (frq(int'(note)) == 0) ? 0 : int'(note);
        end
        m_spk[i] = spk_n;
      end
      e++;
    end
  endtask

  always @(posedge clk or negedge rst_n) model_tick();

  // Every cycle, both instances must match the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("spk%0d", i), spk_w[i], m_spk[i]);
      check($sformatf("busy%0d", i), busy_w[i], m_run[i]);
      check($sformatf("cur_note%0d", i), cur_w[i], m_note[i]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int c);
    note = 5'(c);
    note_load = 1'b1;
    @(negedge clk);
    note_load = 1'b0;
  endtask

  task automatic wait_edge(input int i, input string name);
    logic v;
    int   k;
    v = spk_w[i];
    k = 0;
    while (spk_w[i] == v && k < 3000) begin @(negedge clk); k++; end
    if (k >= 3000) check({name, "_timeout"}, k, 0);
  endtask

  task automatic measure_run(input int i, output int len);
    logic v;
    v = spk_w[i];
    len = 0;
    while (spk_w[i] == v && len < 3000) begin @(negedge clk); len++; end
  endtask

  task automatic wait_rise(input int i, input string name);
    int k;
    k = 0;
    while (spk_w[i] == 1'b1 && k < 3000) begin @(negedge clk); k++; end
    while (spk_w[i] == 1'b0 && k < 3000) begin @(negedge clk); k++; end
    if (k >= 3000) check({name, "_timeout"}, k, 0);
  endtask

  initial begin
    int k, len, acc, bsy, r;

    // Reset held with load strobes: outputs stay at rest.
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      note = 5'($urandom_range(1, 14));
      note_load = 1'b1;
      @(negedge clk);
      note_load = 1'b0;
    end
    check("reset_spk", spk_w[0], 0);
    check("reset_busy", busy_w[0], 0);
    rst_n = 1'b1;
    cyc(20);
    check("idle_busy", busy_w[0], 0);
    check("idle_cur_note", cur_w[0], 0);

    // Note 6 from IDLE: H=568, first rise 569 cycles after the apply edge.
    vol = 2'd3;
    play_en = 1'b1;
    load(6);
    cyc(1);
    check("apply_busy", busy_w[0], 1);
    check("apply_cur_note", cur_w[0], 6);
    k = 0;
    while (spk_w[0] == 1'b0 && k < 3000) begin @(negedge clk); k++; end
    check("first_rise", k, 569);
    measure_run(0, len);
    check("n6_high", len, 568);
    measure_run(0, len);
    check("n6_low", len, 568);

    // Note 1 then a mid-phase switch to note 14: switch at the first boundary.
    load(1);
    cyc(1300);
    wait_edge(0, "n1_edge");
    cyc(400);
    load(14);
    wait_edge(0, "n14_edge");
    measure_run(0, len);
    check("mid_switch", len, 253);

    // Load at the terminal-count cycle: old half-period once more, then the new one.
    load(1);
    cyc(1200);
    k = 0;
    while (m_nt[0] != e && k < 3000) begin @(negedge clk); k++; end
    check("tc_align", (k < 3000) ? 1 : 0, 1);
    note = 5'd14;
    note_load = 1'b1;
    @(negedge clk);
    note_load = 1'b0;
    wait_edge(0, "tc_edge");
    measure_run(0, len);
    check("tc_old_phase", len, 956);
    measure_run(0, len);
    check("tc_new_phase", len, 253);

    // Rest and invalid codes.
    load(25);
    cyc(2000);
    load(0);
    k = 0;
    while (busy_w[0] == 1'b1 && k < 4000) begin @(negedge clk); k++; end
    check("rest_busy_timeout", (k < 4000) ? 1 : 0, 1);
    cyc(1);
    check("rest_spk", spk_w[0], 0);
    check("rest_cur_note", cur_w[0], 0);
    load(15);
    cyc(3);
    check("code15_busy", busy_w[0], 0);
    check("code15_cur_note", cur_w[0], 0);
    load(1);
    cyc(2);
    check("n1_busy", busy_w[0], 1);
    load(20);
    k = 0;
    while (busy_w[0] == 1'b1 && k < 4000) begin @(negedge clk); k++; end
    check("code20_rest", busy_w[0], 0);

    // Volume gating inside tone-high phases of note 6.
    load(6);
    cyc(2);
    wait_rise(0, "v1_rise");
    vol = 2'd1;
    @(negedge clk);
    acc = 0;
    for (int i = 0; i < 16; i++) begin acc += int'(spk_w[0]); @(negedge clk); end
    check("vol1_duty", acc, 4);
    vol = 2'd3;
    wait_rise(0, "v2_rise");
    vol = 2'd2;
    @(negedge clk);
    acc = 0;
    for (int i = 0; i < 16; i++) begin acc += int'(spk_w[0]); @(negedge clk); end
    check("vol2_duty", acc, 8);
    vol = 2'd0;
    @(negedge clk);
    acc = 0;
    bsy = 0;
    for (int i = 0; i < 1200; i++) begin
      acc += int'(spk_w[0]); bsy += int'(busy_w[0]); @(negedge clk);
    end
    check("vol0_spk", acc, 0);
    check("vol0_busy", bsy, 1200);
    vol = 2'd3;

    // Octave shift, play_en gap, asynchronous reset mid-note.
    load(25);
    cyc(2500);
    wait_edge(1, "oct_edge");
    measure_run(1, len);
    check("oct_phase", len, 954);
    play_en = 1'b0;
    acc = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      acc += int'(spk_w[0]) + int'(spk_w[1]);
    end
    check("gap_spk", acc, 0);
    play_en = 1'b1;
    cyc(3000);
    check("pre_reset_busy", busy_w[1], 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_spk0", spk_w[0], 0);
    check("async_busy0", busy_w[0], 0);
    check("async_spk1", spk_w[1], 0);
    check("async_busy1", busy_w[1], 0);
    check("async_cur1", cur_w[1], 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    check("post_reset_busy", busy_w[0], 0);

    // Randomized loads, volumes and gating against the model.
    for (int it = 0; it < 250; it++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0: k = 0;
        1: k = 15 + int'($urandom_range(0, 9));
        2: k = 14;
        3: k = 1;
        default: k = int'($urandom_range(0, 31));
      endcase
      load(k);
      vol = 2'($urandom_range(0, 3));
      play_en = ($urandom_range(0, 9) != 0);
      cyc(int'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : $urandom_range(1, 250)));
    end
    cyc(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
